// File: rtl/cs_fifo_arb_pkg.sv
// Shared types and widths for the cs_fifo write-side arbiter.
package cs_fifo_arb_pkg;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t BURST = 1'b1;

  localparam int BEAT_CNT_W  = 8;
  localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/cs_rr_pick.sv
// Round-robin pick: first valid requester searching upward from last_owner+1, wrapping.
module cs_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  assign any = |valid;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    sum      = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_owner} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && valid[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cs_fifo_wr_arb.sv
// Multi-requester burst arbiter feeding the cs_fifo write port (IDLE/BURST FSM).
// Optional per-requester beat counters on word_cnt: define CS_FIFO_WR_ARB_STATS_EN.
//
// Handshake: a beat transfers on a wrclk edge where req_valid[g] & req_ready[g];
// the same cycle drives wrreq/data to the FIFO, so there is no buffering here.
module cs_fifo_wr_arb
  import cs_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                      wrclk,
  input  logic                      sclr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wrfull,
  output logic                      wrreq,
  output logic [DATA_W-1:0]         data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef CS_FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0] word_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t              state;
  logic [IDX_W-1:0]        last_owner;
  logic [IDX_W-1:0]        owner;
  logic [NUM_REQ-1:0]      grant_q;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [NUM_REQ-1:0]      pick;
  logic [IDX_W-1:0]        pick_idx;
  logic                    any_valid;
  logic                    accept;
  logic                    burst_done;

  cs_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid      (req_valid),
    .last_owner (last_owner),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (any_valid)
  );

  assign busy  = (state == BURST);
  assign grant = grant_q;
  // sclr kills the write strobe in its own cycle so an aborted burst leaves nothing behind
  assign accept    = busy & req_valid[owner] & ~wrfull & ~sclr;
  assign wrreq     = accept;
  assign req_ready = (busy & ~wrfull & ~sclr) ? grant_q : '0;
  assign data      = req_data[owner*DATA_W +: DATA_W];
  assign burst_done = req_last[owner] |
                      ({1'b0, beat_cnt} == (BEAT_CNT_W+1)'(MAX_BURST-1));

  always_ff @(posedge wrclk) begin
    if (sclr) begin
      state      <= IDLE;
      last_owner <= IDX_W'(NUM_REQ-1);
      owner      <= '0;
      grant_q    <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= BURST;
            grant_q  <= pick;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (burst_done) begin
              state      <= IDLE;
              grant_q    <= '0;
              last_owner <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CS_FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*STATS_CNT_W-1:0] word_cnt_q;

  always_ff @(posedge wrclk) begin
    if (sclr) begin
      word_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && owner == IDX_W'(i))
          word_cnt_q[i*STATS_CNT_W +: STATS_CNT_W] <=
            word_cnt_q[i*STATS_CNT_W +: STATS_CNT_W] + 1'b1;
      end
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
